object_physics_stepper: RTL and testbench
=========================================

Name: object_physics_stepper

Overview:
- Per-frame physics integrator placed directly downstream and upstream of object_storage.
- On each step pulse it reads object records four at a time through the storage's four read lanes, then applies gravity and velocity integration.
- Results are written back one object per cycle through the storage write port.
- Static objects are left untouched.

Parameters:
- OBJ_COUNT, 4, number of stored objects; valid addresses are 0..OBJ_COUNT-1
- OBJ_WIDTH, 115, record width
- ADDR_WIDTH, 8, object address width
- GRAVITY, 16'sd1, signed increment added to vel_y each step

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- step_in  input  1  one-cycle pulse that starts a physics step
- busy_out  output  1  high while a step is in progress
- done_out  output  1  one-cycle pulse when a step completes
- read_valid_out  output  1  read request to storage, one-cycle pulse per batch
- read_addrs_out[3:0]  output  ADDR_WIDTH each  lane addresses
- read_valid_in  input  1  storage read-data-valid (nominally 2 cycles after request)
- read_objects_in[3:0]  input  OBJ_WIDTH each  lane data
- write_valid_out  output  1  write strobe, one cycle per object
- write_addr_out  output  ADDR_WIDTH  write address
- write_object_out  output  OBJ_WIDTH  updated record

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. All outputs are 0, read_addrs_out are all 0, FSM is IDLE, counters are 0. Asserting reset mid-step aborts immediately with no further writes and no done_out.
- Record layout, MSB first: is_static[114], id[113:112], params[111:64], pos_x[63:48], pos_y[47:32], vel_x[31:16], vel_y[15:0]. pos and vel are signed 16-bit.
- FSM states: IDLE, REQ, WAIT, WRITE, DONE.
- IDLE:
  - step_in=1 -> batch base = 0, go to REQ, busy_out=1.
  - step_in while busy is ignored and not queued.
- REQ:
  - Drive read_addrs_out[i] = base+i and pulse read_valid_out for one cycle, then go to WAIT.
- WAIT:
  - Hold until read_valid_in=1.
  - On that cycle, latch all four read_objects_in into a local batch register, lane index = 0, go to WRITE.
  - No timeout.
- WRITE: one lane per cycle, lane 0..3 in order.
  - Lane skipped (no strobe, no cycle wasted beyond 1) if base+lane >= OBJ_COUNT or is_static=1.
  - Otherwise write_valid_out=1, write_addr_out=base+lane, and write_object_out holds the updated record:
    - vel_y' = sat16(vel_y + GRAVITY)
    - pos_x' = sat16(pos_x + vel_x)
    - pos_y' = sat16(pos_y + vel_y'), using the new velocity (semi-implicit Euler)
    - vel_x and all other fields unchanged.
  - sat16 computes in 17-bit signed and clamps to [-32768, 32767].
  - After lane 3: base += 4. If base >= OBJ_COUNT go to DONE, else go to REQ.
- DONE:
  - done_out=1 for one cycle, busy_out=0, return to IDLE.
- Timing with OBJ_COUNT=4, all dynamic, storage latency 2:
  - step_in at cycle 0 -> read_valid_out at 1 -> read_valid_in at 3 -> writes at 4,5,6,7 -> done_out at 8.
- Outputs are registered. write_valid_out is 0 in all states except WRITE with a non-skipped lane.
- Read/write hazards: the storage is read-first and batches never overlap addresses, so no hazard exists.

Optional Feature:
- Macro: FLOOR_CLAMP_EN.
- When defined, a parameter FLOOR_Y (default 16'sd400) is added. After integration, if pos_y' > FLOOR_Y then pos_y' = FLOOR_Y and vel_y' = 0 (the object rests on the floor).
- When undefined, there is no clamp and no FLOOR_Y parameter; behaviour is exactly as above.

Test Plan:
- Single dynamic object: addr0 = {0, id 1, params 0, pos (10,20), vel (3,-5)}, GRAVITY=1. Step -> write addr0 with pos (13,16), vel (3,-4); done_out at cycle 8.
- Static skip: addr1 is_static=1, others dynamic. Step -> write strobes only for addrs 0, 2, 3; addr1 is never written.
- Saturation: pos_x=32760, vel_x=100 -> pos_x'=32767. vel_y=32767 -> vel_y' stays 32767.
- OBJ_COUNT=6: two batches. Second REQ uses addrs 4,5,6,7; only 4 and 5 are written. done_out once.
- Reset mid-step: rst_n_in low during WRITE lane 1 -> all outputs go 0 immediately, no further writes. A new step_in after release runs the full sequence.
- FLOOR_CLAMP_EN defined, FLOOR_Y=400: pos_y=398, vel_y=5 -> pos_y'=400, vel_y'=0. step_in held high while busy -> only one done_out.

Source files
------------

// File: rtl/object_physics_stepper.sv
// Per-frame integrator: reads object records four at a time, applies gravity and
// semi-implicit Euler, writes dynamic records back one per cycle. Optional macro: FLOOR_CLAMP_EN.
module object_physics_stepper #(
  parameter int                 OBJ_COUNT  = 4,
  parameter int                 OBJ_WIDTH  = 115,
  parameter int                 ADDR_WIDTH = 8,
  parameter logic signed [15:0] GRAVITY    = 16'sd1
`ifdef FLOOR_CLAMP_EN
  ,
  parameter logic signed [15:0] FLOOR_Y    = 16'sd400
`endif
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic                                step_in,
  output logic                                busy_out,
  output logic                                done_out,
  output logic                                read_valid_out,
  output logic [3:0][ADDR_WIDTH-1:0]          read_addrs_out,
  input  logic                                read_valid_in,
  input  logic [3:0][OBJ_WIDTH-1:0]           read_objects_in,
  output logic                                write_valid_out,
  output logic [ADDR_WIDTH-1:0]               write_addr_out,
  output logic [OBJ_WIDTH-1:0]                write_object_out
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] OBJ_COUNT_W = (ADDR_WIDTH+1)'(OBJ_COUNT);

  state_t                        state_q, state_d;
  logic [ADDR_WIDTH:0]           base_q, base_d;
  logic [1:0]                    lane_q, lane_d;
  logic [3:0][OBJ_WIDTH-1:0]     batch_q, batch_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          rd_valid_q, rd_valid_d;
  logic [3:0][ADDR_WIDTH-1:0]    rd_addrs_q, rd_addrs_d;
  logic                          wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0]         wr_addr_q, wr_addr_d;
  logic [OBJ_WIDTH-1:0]          wr_obj_q, wr_obj_d;

  logic                          emit;
  logic [1:0]                    emit_lane;
  logic [1:0]                    lane_nx;
  logic [OBJ_WIDTH-1:0]          emit_src;
  logic [ADDR_WIDTH:0]           lane_addr;

  function automatic logic signed [15:0] sat16(input logic signed [16:0] s);
    if (s > 17'sd32767)       return 16'sh7FFF;
    else if (s < -17'sd32768) return 16'sh8000;
    else                      return s[15:0];
  endfunction

  // Velocity first, then position from the new velocity (semi-implicit Euler).
  function automatic logic [OBJ_WIDTH-1:0] integrate(input logic [OBJ_WIDTH-1:0] o);
    logic signed [15:0] px, py, vx, vy;
    px = o[63:48];
    py = o[47:32];
    vx = o[31:16];
    vy = o[15:0];
    vy = sat16($signed({vy[15], vy}) + $signed({GRAVITY[15], GRAVITY}));
    px = sat16($signed({px[15], px}) + $signed({vx[15], vx}));
    py = sat16($signed({py[15], py}) + $signed({vy[15], vy}));
`ifdef FLOOR_CLAMP_EN
    if (py > FLOOR_Y) begin
      py = FLOOR_Y;
      vy = '0;
    end
`endif
    return {o[OBJ_WIDTH-1:64], px, py, vx, vy};
  endfunction

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    lane_d     = lane_q;
    batch_d    = batch_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_addrs_d = rd_addrs_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_obj_d   = wr_obj_q;
    emit       = 1'b0;
    lane_nx    = lane_q + 2'd1;
    emit_lane  = lane_nx;
    emit_src   = batch_q[lane_nx];
    lane_addr  = '0;

    case (state_q)
      IDLE: begin
        if (step_in) begin
          base_d     = '0;
          busy_d     = 1'b1;
          rd_valid_d = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (read_valid_in) begin
          batch_d   = read_objects_in;
          lane_d    = 2'd0;
          emit      = 1'b1;
          emit_lane = 2'd0;
          emit_src  = read_objects_in[0];
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (lane_q == 2'd3) begin
          base_d = base_q + (ADDR_WIDTH+1)'(4);
          if (base_d >= OBJ_COUNT_W) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            rd_valid_d = 1'b1;
            state_d    = REQ;
          end
        end else begin
          lane_d = lane_nx;
          emit   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rd_valid_d) begin
      for (int i = 0; i < 4; i++) begin
        rd_addrs_d[i] = ADDR_WIDTH'(base_d + (ADDR_WIDTH+1)'(i));
      end
    end

    // Each lane costs exactly one cycle; out-of-range and static lanes simply drop the strobe.
    if (emit) begin
      lane_addr = base_q + (ADDR_WIDTH+1)'(emit_lane);
      if ((lane_addr < OBJ_COUNT_W) && !emit_src[OBJ_WIDTH-1]) begin
        wr_valid_d = 1'b1;
        wr_addr_d  = lane_addr[ADDR_WIDTH-1:0];
        wr_obj_d   = integrate(emit_src);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      base_q     <= '0;
      lane_q     <= '0;
      batch_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addrs_q <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_obj_q   <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      lane_q     <= lane_d;
      batch_q    <= batch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_addrs_q <= rd_addrs_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_obj_q   <= wr_obj_d;
    end
  end

  assign busy_out         = busy_q;
  assign done_out         = done_q;
  assign read_valid_out   = rd_valid_q;
  assign read_addrs_out   = rd_addrs_q;
  assign write_valid_out  = wr_valid_q;
  assign write_addr_out   = wr_addr_q;
  assign write_object_out = wr_obj_q;

endmodule

// File: tb/tb_object_physics_stepper.sv
// Bench for object_physics_stepper: two instances (OBJ_COUNT 4 and 6) against a
// storage model with 2-cycle read latency and an arithmetic reference model.
module tb_object_physics_stepper;
  localparam int AW    = 8;
  localparam int OW    = 115;
  localparam int GRAV  = 1;
  localparam int FLOOR = 400;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic step  = 1'b0;
  always #5 clk = ~clk;

  logic                 busy   [2];
  logic                 done   [2];
  logic                 rv_out [2];
  logic [3:0][AW-1:0]   raddrs [2];
  logic                 rv_in  [2];
  logic [3:0][OW-1:0]   robjs  [2];
  logic                 wv     [2];
  logic [AW-1:0]        wa     [2];
  logic [OW-1:0]        wo     [2];

  object_physics_stepper #(.OBJ_COUNT(4)) u_dut4 (
    .clk_in(clk), .rst_n_in(rst_n), .step_in(step),
    .busy_out(busy[0]), .done_out(done[0]),
    .read_valid_out(rv_out[0]), .read_addrs_out(raddrs[0]),
    .read_valid_in(rv_in[0]), .read_objects_in(robjs[0]),
    .write_valid_out(wv[0]), .write_addr_out(wa[0]), .write_object_out(wo[0]));

  object_physics_stepper #(.OBJ_COUNT(6)) u_dut6 (
    .clk_in(clk), .rst_n_in(rst_n), .step_in(step),
    .busy_out(busy[1]), .done_out(done[1]),
    .read_valid_out(rv_out[1]), .read_addrs_out(raddrs[1]),
    .read_valid_in(rv_in[1]), .read_objects_in(robjs[1]),
    .write_valid_out(wv[1]), .write_addr_out(wa[1]), .write_object_out(wo[1]));

  // Storage model: contents are preloaded per step; reads return two cycles after request.
  logic [OW-1:0]      mem  [2][8];
  logic               p1_v [2];
  logic               p2_v [2];
  logic [3:0][AW-1:0] p1_a [2];
  logic [3:0][AW-1:0] p2_a [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      p1_v[d] <= rv_out[d];
      p1_a[d] <= raddrs[d];
      p2_v[d] <= p1_v[d];
      p2_a[d] <= p1_a[d];
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      rv_in[d] = p2_v[d];
      for (int l = 0; l < 4; l++) robjs[d][l] = mem[d][p2_a[d][l][2:0]];
    end
  end

  // Transaction logs, sampled on the falling edge.
  int                 cyc = 0;
  logic [AW-1:0]      wl_a [2][256];
  logic [OW-1:0]      wl_o [2][256];
  int                 wl_c [2][256];
  int                 wcnt [2] = '{0, 0};
  logic [3:0][AW-1:0] rl_a [2][64];
  int                 rl_c [2][64];
  int                 rcnt [2] = '{0, 0};
  int                 dcnt [2] = '{0, 0};
  int                 dcyc [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wv[d] && wcnt[d] < 256) begin
        wl_a[d][wcnt[d]] <= wa[d];
        wl_o[d][wcnt[d]] <= wo[d];
        wl_c[d][wcnt[d]] <= cyc;
        wcnt[d]          <= wcnt[d] + 1;
      end
      if (rv_out[d] && rcnt[d] < 64) begin
        rl_a[d][rcnt[d]] <= raddrs[d];
        rl_c[d][rcnt[d]] <= cyc;
        rcnt[d]          <= rcnt[d] + 1;
      end
      if (done[d]) begin
        dcnt[d] <= dcnt[d] + 1;
        dcyc[d] <= cyc;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int snap_s;
  int snap_w [2];
  int snap_r [2];
  int snap_d [2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [OW-1:0] ref_update(input logic [OW-1:0] o);
    logic signed [15:0] t;
    int px, py, vx, vy;
    logic [15:0] opx, opy, ovx, ovy;
    t = o[63:48]; px = t;
    t = o[47:32]; py = t;
    t = o[31:16]; vx = t;
    t = o[15:0];  vy = t;
    vy = sat(vy + GRAV);
    px = sat(px + vx);
    py = sat(py + vy);
`ifdef FLOOR_CLAMP_EN
    if (py > FLOOR) begin
      py = FLOOR;
      vy = 0;
    end
`endif
    opx = px[15:0]; opy = py[15:0]; ovx = vx[15:0]; ovy = vy[15:0];
    return {o[114:64], opx, opy, ovx, ovy};
  endfunction

  // mode 0: 25% static, 1: all dynamic, 2: all static
  task automatic fill(input int mode);
    logic [OW-1:0] r;
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 8; a++) begin
        r[31:0]   = $urandom;
        r[63:32]  = $urandom;
        r[95:64]  = $urandom;
        r[114:96] = 19'($urandom);
        r[114]    = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : ($urandom_range(0, 3) == 0);
        mem[d][a] = r;
      end
    end
  endtask

  task automatic check_step(input int d, input int n);
    int nb, k, ecyc;
    nb = (n + 3) / 4;
    k  = 0;
    for (int a = 0; a < n; a++) begin
      if (!mem[d][a][OW-1]) begin
        ecyc = snap_s + 4 + 7 * (a / 4) + (a % 4);
        if (snap_w[d] + k < wcnt[d]) begin
          chk($sformatf("d%0d_wr_addr_%0d", d, a), wl_a[d][snap_w[d]+k], a);
          chk($sformatf("d%0d_wr_obj_%0d", d, a), wl_o[d][snap_w[d]+k], ref_update(mem[d][a]));
          chk($sformatf("d%0d_wr_cycle_%0d", d, a), wl_c[d][snap_w[d]+k], ecyc);
        end
        k++;
      end
    end
    chk($sformatf("d%0d_wr_count", d), wcnt[d] - snap_w[d], k);
    chk($sformatf("d%0d_done_count", d), dcnt[d] - snap_d[d], 1);
    chk($sformatf("d%0d_done_cycle", d), dcyc[d], snap_s + 8 + 7 * (nb - 1));
    chk($sformatf("d%0d_rd_count", d), rcnt[d] - snap_r[d], nb);
    for (int b = 0; b < nb; b++) begin
      if (snap_r[d] + b < rcnt[d]) begin
        chk($sformatf("d%0d_rd_cycle_%0d", d, b), rl_c[d][snap_r[d]+b], snap_s + 1 + 7 * b);
        for (int l = 0; l < 4; l++)
          chk($sformatf("d%0d_rd_addr_%0d_%0d", d, b, l), rl_a[d][snap_r[d]+b][l], 4 * b + l);
      end
    end
    chk($sformatf("d%0d_idle_busy", d), busy[d], 1'b0);
  endtask

  task automatic run_step(input int hold);
    int t;
    for (int d = 0; d < 2; d++) begin
      snap_w[d] = wcnt[d];
      snap_r[d] = rcnt[d];
      snap_d[d] = dcnt[d];
    end
    @(negedge clk);
    step   = 1'b1;
    snap_s = cyc;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_busy_after_step", d), busy[d], 1'b1);
      chk($sformatf("d%0d_rv_after_step", d), rv_out[d], 1'b1);
    end
    repeat (hold - 1) @(negedge clk);
    step = 1'b0;
    t = 0;
    while ((dcnt[0] == snap_d[0] || dcnt[1] == snap_d[1]) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("done_within_budget", (t < 100), 1'b1);
    repeat (4) @(negedge clk);
    check_step(0, 4);
    check_step(1, 6);
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_d%0d_outs", tag, d),
          {busy[d], done[d], rv_out[d], wv[d], raddrs[d], wa[d]}, '0);
      chk($sformatf("%s_d%0d_wobj", tag, d), wo[d], '0);
    end
  endtask

  initial begin
    logic [OW-1:0] lit;
    fill(2);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single dynamic object with known result.
    fill(2);
    for (int d = 0; d < 2; d++) mem[d][0] = {1'b0, 2'd1, 48'd0, 16'd10, 16'd20, 16'd3, 16'hFFFB};
    run_step(1);
    lit = {1'b0, 2'd1, 48'd0, 16'd13, 16'd16, 16'd3, 16'hFFFC};
    chk("single_obj_literal", wl_o[0][snap_w[0]], lit);
    chk("single_obj_done_cycle", dcyc[0] - snap_s, 8);

    // Static object at address 1.
    fill(1);
    for (int d = 0; d < 2; d++) mem[d][1][114] = 1'b1;
    run_step(1);
    chk("static_skip_count", wcnt[0] - snap_w[0], 3);

    // Saturation at both ends.
    fill(1);
    for (int d = 0; d < 2; d++) begin
      mem[d][0][63:48] = 16'd32760;
      mem[d][0][31:16] = 16'd100;
      mem[d][0][15:0]  = 16'h7FFF;
      mem[d][2][63:48] = 16'h8008;
      mem[d][2][31:16] = 16'hFF9C;
    end
    run_step(1);
    chk("sat_pos_x", wl_o[0][snap_w[0]][63:48], 16'h7FFF);
`ifndef FLOOR_CLAMP_EN
    chk("sat_vel_y", wl_o[0][snap_w[0]][15:0], 16'h7FFF);
`endif

    // Randomised steps.
    for (int i = 0; i < 6; i++) begin
      fill(0);
      run_step(1);
    end

    // step_in held high across the busy period.
    fill(0);
    run_step(5);

`ifdef FLOOR_CLAMP_EN
    fill(1);
    for (int d = 0; d < 2; d++) begin
      mem[d][0][47:32] = 16'd398;
      mem[d][0][15:0]  = 16'd5;
    end
    run_step(1);
    chk("floor_pos_y", wl_o[0][snap_w[0]][47:32], 16'd400);
    chk("floor_vel_y", wl_o[0][snap_w[0]][15:0], 16'd0);
`endif

    // Reset during lane 1 of the first batch.
    fill(1);
    for (int d = 0; d < 2; d++) begin
      snap_w[d] = wcnt[d];
      snap_d[d] = dcnt[d];
    end
    @(negedge clk);
    step   = 1'b1;
    snap_s = cyc;
    @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
    chk("midreset_lane1_strobe", wv[0], 1'b1);
    chk("midreset_lane1_addr", wa[0], 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (5) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midreset_d%0d_writes", d), wcnt[d] - snap_w[d], 2);
      chk($sformatf("midreset_d%0d_no_done", d), dcnt[d] - snap_d[d], 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fill(0);
    run_step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
